instr_fetch_sequencer: RTL

- Reader side of the instruction-ROM interface.
- Drives program select and address into the combinational 8-bit instruction ROM, then latches and decodes each returned byte.
- Issues one decoded operation at a time to the datapath (ALU/register file) over a valid/ready handshake.
- Sits between the ROM and the datapath; it is the processor's control unit.

---
 rtl/instr_fetch_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_sequencer.sv
// Control unit: fetches 8-bit instructions from the program ROM, decodes them and issues one
// operation at a time to the datapath. Define SEQ_SINGLE_STEP_EN to add a `step`-gated PAUSE state.
module instr_fetch_sequencer #(
    parameter logic [7:0]  LAST_ADDR = 8'hFF,
    parameter int unsigned OUT_HALTS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [1:0] prog_sel,
    output logic [1:0] rom_prog,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       op_valid,
    input  logic       op_ready,
    output logic [3:0] opcode,
    output logic [1:0] ra,
    output logic [1:0] rb,
    output logic       is_alu,
    output logic       ld_alu,
    output logic       ld_a,
    output logic       ld_b,
    output logic       out_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [3:0] OP_OUT = 4'b1011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_DONE
`ifdef SEQ_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] ir;
    logic [4:0] strobes;
    logic       launch;
    logic       advance;
    logic       xfer;
    logic       finish;
    logic       reserved;

    // One-hot strobe vector {is_alu, ld_alu, ld_a, ld_b, out_en}; reserved opcodes give all zeros.
    function automatic logic [4:0] decode_strobes(input logic [3:0] op);
        logic [4:0] s;
        s = 5'b00000;
        if (op[3] == 1'b0) begin
            s[4] = 1'b1;
        end else begin
            case (op[2:0])
                3'b000:  s[3] = 1'b1;
                3'b001:  s[2] = 1'b1;
                3'b010:  s[1] = 1'b1;
                3'b011:  s[0] = 1'b1;
                default: s    = 5'b00000;
            endcase
        end
        return s;
    endfunction

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        advance   = 1'b0;
        xfer      = (state == S_EXEC) && op_ready;
        finish    = xfer && ((rom_addr == LAST_ADDR) ||
                             ((OUT_HALTS != 0) && (opcode == OP_OUT)));
        reserved  = (ir[7:6] == 2'b11);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = reserved ? S_DONE : S_EXEC;
            S_EXEC: begin
                if (xfer) begin
                    if (finish) begin
                        state_nxt = S_DONE;
                    end else begin
`ifdef SEQ_SINGLE_STEP_EN
                        state_nxt = S_PAUSE;
`else
                        advance   = 1'b1;
                        state_nxt = S_FETCH;
`endif
                    end
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    advance   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
        // abort wins over everything, including start and a pending transfer
        if (abort) begin
            state_nxt = S_IDLE;
            launch    = 1'b0;
            advance   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_prog <= 2'b00;
            rom_addr <= 8'h00;
            ir       <= 8'h00;
            opcode   <= 4'h0;
            ra       <= 2'b00;
            rb       <= 2'b00;
            strobes  <= 5'b00000;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (launch) begin
                rom_prog <= prog_sel;
                rom_addr <= 8'h00;
            end else if (advance) begin
                rom_addr <= rom_addr + 8'd1;
            end

            if (state == S_FETCH) begin
                ir <= rom_data;
            end

            if (state == S_DECODE) begin
                opcode <= ir[7:4];
                ra     <= ir[3:2];
                rb     <= ir[1:0];
            end

            if (abort) begin
                strobes <= 5'b00000;
            end else if ((state == S_DECODE) && !reserved) begin
                strobes <= decode_strobes(ir[7:4]);
            end else if (xfer) begin
                strobes <= 5'b00000;
            end

            if (abort || launch) begin
                done <= 1'b0;
                err  <= 1'b0;
            end else if ((state == S_DECODE) && reserved) begin
                done <= 1'b1;
                err  <= 1'b1;
            end else if (finish) begin
                done <= 1'b1;
            end
        end
    end

    assign op_valid = (state == S_EXEC);
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign {is_alu, ld_alu, ld_a, ld_b, out_en} = strobes;

endmodule
